ntp_recv_parse: RTL and testbench

Receive-side counterpart of the NTP request builder: consumes the byte stream of one received NTP UDP payload and extracts the server reply fields and timestamps. It validates the header and checks that the origin timestamp matches the last client transmit timestamp. It then presents the fields to the clock-discipline logic with a one-cycle valid strobe. It sits between the UDP receive demux and the NTP time-offset calculator.

---
 rtl/ntp_pkg.sv | 34 +++
 rtl/ntp_field_shift.sv | 20 ++
 rtl/ntp_recv_parse.sv | 169 ++++++++++++++++
 tb/tb_ntp_recv_parse.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntp_pkg.sv
// rtl/ntp_pkg.sv - NTP packet layout, mode and error-code constants shared by the request builder and reply parser
package ntp_pkg;

  localparam int NTP_OFS_DELAY  = 4;
  localparam int NTP_OFS_DISPER = 8;
  localparam int NTP_OFS_REF    = 16;
  localparam int NTP_OFS_ORIG   = 24;
  localparam int NTP_OFS_RECV   = 32;
  localparam int NTP_OFS_XMIT   = 40;
  localparam int NTP_PKT_LEN    = 48;

  localparam logic [2:0] NTP_MODE_SERVER = 3'd4;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_LEN     = 3'd1;
  localparam logic [2:0] ERR_MODE    = 3'd2;
  localparam logic [2:0] ERR_VERSION = 3'd3;
  localparam logic [2:0] ERR_STRATUM = 3'd4;
  localparam logic [2:0] ERR_ORIGIN  = 3'd5;
  localparam logic [2:0] ERR_RESYNC  = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_CHECK,
    ST_COMMIT,
    ST_ERR
  } state_t;

  function automatic logic in_field(input logic [10:0] idx, input int ofs, input int n);
    return (int'(idx) >= ofs) && (int'(idx) < ofs + n);
  endfunction

endpackage

// File: rtl/ntp_field_shift.sv
// rtl/ntp_field_shift.sv - byte-wide shift register that assembles a big-endian field
module ntp_field_shift #(
  parameter int W = 64
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic [7:0]   i_byte,
  output logic [W-1:0] o_q
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_q <= '0;
    end else if (i_en) begin
      o_q <= {o_q[W-9:0], i_byte};
    end
  end

endmodule

// File: rtl/ntp_recv_parse.sv
// rtl/ntp_recv_parse.sv - parses a received NTP reply byte stream, validates it and commits its fields
module ntp_recv_parse
  import ntp_pkg::*;
#(
  parameter int P_MIN_LEN      = 48,
  parameter bit P_CHECK_ORIGIN = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rx_valid,
  input  logic        i_rx_sof,
  input  logic        i_rx_eof,
  input  logic [7:0]  i_rx_data,
  input  logic [63:0] i_ntp_local,
  input  logic [63:0] i_ntp_client_send,
  output logic        o_busy,
  output logic        o_ntp_valid,
  output logic        o_ntp_err,
  output logic [2:0]  o_err_code,
  output logic [1:0]  o_leap,
  output logic [2:0]  o_version,
  output logic [2:0]  o_mode,
  output logic [7:0]  o_stratum,
  output logic [31:0] o_root_delay,
  output logic [31:0] o_root_disper,
  output logic [63:0] o_ref_ts,
  output logic [63:0] o_orig_ts,
  output logic [63:0] o_recv_ts,
  output logic [63:0] o_xmit_ts,
  output logic [63:0] o_dst_ts
);

  state_t      state;
  logic [10:0] cnt;
  logic [2:0]  err_q;
  logic [7:0]  sh_b0, sh_stratum;
  logic        sh_short;
  logic [63:0] sh_dst;
  logic [31:0] sh_delay, sh_disper;
  logic [63:0] sh_ref, sh_orig, sh_recv, sh_xmit;
  logic        sof_ok, accept;
  logic [10:0] idx;
  logic [11:0] len;
  logic [2:0]  chk_code;
  state_t      nxt;

  // A sof is honoured everywhere except CHECK; in RECV it aborts the packet in flight.
  always_comb begin
    sof_ok = i_rx_valid && i_rx_sof && (state inside {ST_IDLE, ST_RECV, ST_COMMIT, ST_ERR});
    accept = sof_ok || (i_rx_valid && state == ST_RECV);
    if (i_rx_sof)           idx = '0;
    else if (cnt == 11'h7FF) idx = cnt;
    else                     idx = cnt + 11'd1;
    len = {1'b0, idx} + 12'd1;
    nxt = i_rx_eof ? ST_CHECK : ST_RECV;
  end

  ntp_field_shift #(.W(32)) u_delay (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_byte(i_rx_data), .o_q(sh_delay),
    .i_en(accept && in_field(idx, NTP_OFS_DELAY, 4)));
  ntp_field_shift #(.W(32)) u_disper (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_byte(i_rx_data), .o_q(sh_disper),
    .i_en(accept && in_field(idx, NTP_OFS_DISPER, 4)));
  ntp_field_shift #(.W(64)) u_ref (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_byte(i_rx_data), .o_q(sh_ref),
    .i_en(accept && in_field(idx, NTP_OFS_REF, 8)));
  ntp_field_shift #(.W(64)) u_orig (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_byte(i_rx_data), .o_q(sh_orig),
    .i_en(accept && in_field(idx, NTP_OFS_ORIG, 8)));
  ntp_field_shift #(.W(64)) u_recv (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_byte(i_rx_data), .o_q(sh_recv),
    .i_en(accept && in_field(idx, NTP_OFS_RECV, 8)));
  ntp_field_shift #(.W(64)) u_xmit (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_byte(i_rx_data), .o_q(sh_xmit),
    .i_en(accept && in_field(idx, NTP_OFS_XMIT, 8)));

  // Rules are ordered; the first failing one names the rejection.
  always_comb begin
    chk_code = ERR_NONE;
    if (sh_short)                                           chk_code = ERR_LEN;
    else if (sh_b0[2:0] != NTP_MODE_SERVER)                 chk_code = ERR_MODE;
    else if (sh_b0[5:3] != 3'd3 && sh_b0[5:3] != 3'd4)      chk_code = ERR_VERSION;
    else if (sh_stratum == 8'd0 || sh_stratum > 8'd15)      chk_code = ERR_STRATUM;
    else if (P_CHECK_ORIGIN && sh_orig != i_ntp_client_send) chk_code = ERR_ORIGIN;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      err_q         <= ERR_NONE;
      sh_b0         <= '0;
      sh_stratum    <= '0;
      sh_short      <= 1'b0;
      sh_dst        <= '0;
      o_busy        <= 1'b0;
      o_ntp_valid   <= 1'b0;
      o_ntp_err     <= 1'b0;
      o_err_code    <= ERR_NONE;
      o_leap        <= '0;
      o_version     <= '0;
      o_mode        <= '0;
      o_stratum     <= '0;
      o_root_delay  <= '0;
      o_root_disper <= '0;
      o_ref_ts      <= '0;
      o_orig_ts     <= '0;
      o_recv_ts     <= '0;
      o_xmit_ts     <= '0;
      o_dst_ts      <= '0;
    end else begin
      o_ntp_valid <= 1'b0;
      o_ntp_err   <= 1'b0;
      if (accept) begin
        cnt <= idx;
        if (idx == 11'd0) sh_b0 <= i_rx_data;
        if (idx == 11'd1) sh_stratum <= i_rx_data;
        if (i_rx_sof) sh_dst <= i_ntp_local;
        if (i_rx_eof) sh_short <= (int'(len) < P_MIN_LEN);
      end
      case (state)
        ST_IDLE: begin
          o_busy <= sof_ok;
          if (sof_ok) state <= nxt;
        end
        ST_RECV: begin
          o_busy <= 1'b1;
          if (sof_ok) begin
            o_ntp_err  <= 1'b1;
            o_err_code <= ERR_RESYNC;
          end
          if (i_rx_valid && i_rx_eof) state <= ST_CHECK;
        end
        ST_CHECK: begin
          o_busy <= 1'b1;
          err_q  <= chk_code;
          state  <= (chk_code == ERR_NONE) ? ST_COMMIT : ST_ERR;
        end
        ST_COMMIT: begin
          o_busy        <= 1'b1;
          o_ntp_valid   <= 1'b1;
          o_leap        <= sh_b0[7:6];
          o_version     <= sh_b0[5:3];
          o_mode        <= sh_b0[2:0];
          o_stratum     <= sh_stratum;
          o_root_delay  <= sh_delay;
          o_root_disper <= sh_disper;
          o_ref_ts      <= sh_ref;
          o_orig_ts     <= sh_orig;
          o_recv_ts     <= sh_recv;
          o_xmit_ts     <= sh_xmit;
          o_dst_ts      <= sh_dst;
          state         <= sof_ok ? nxt : ST_IDLE;
        end
        ST_ERR: begin
          o_busy     <= 1'b1;
          o_ntp_err  <= 1'b1;
          o_err_code <= err_q;
          state      <= sof_ok ? nxt : ST_IDLE;
        end
        default: begin
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ntp_recv_parse.sv
// tb/tb_ntp_recv_parse.sv - self-checking bench for ntp_recv_parse (origin check on and off)
module tb_ntp_recv_parse;

  localparam logic [63:0] CLIENT = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] XMIT1  = 64'hE000_0001_8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0, rx_sof = 1'b0, rx_eof = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic [63:0] ntp_local = 64'h1000_0000_0000_0000;

  always #5 clk = ~clk;
  always @(posedge clk) ntp_local <= ntp_local + 64'h0000_0001_0000_1000;

  logic        a_busy, a_valid, a_err, b_busy, b_valid, b_err;
  logic [2:0]  a_code, a_version, a_mode, b_code, b_version, b_mode;
  logic [1:0]  a_leap, b_leap;
  logic [7:0]  a_stratum, b_stratum;
  logic [31:0] a_delay, a_disper, b_delay, b_disper;
  logic [63:0] a_ref, a_orig, a_recv, a_xmit, a_dst;
  logic [63:0] b_ref, b_orig, b_recv, b_xmit, b_dst;

  ntp_recv_parse #(.P_MIN_LEN(48), .P_CHECK_ORIGIN(1'b1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_valid(rx_valid), .i_rx_sof(rx_sof), .i_rx_eof(rx_eof),
    .i_rx_data(rx_data), .i_ntp_local(ntp_local), .i_ntp_client_send(CLIENT),
    .o_busy(a_busy), .o_ntp_valid(a_valid), .o_ntp_err(a_err), .o_err_code(a_code),
    .o_leap(a_leap), .o_version(a_version), .o_mode(a_mode), .o_stratum(a_stratum),
    .o_root_delay(a_delay), .o_root_disper(a_disper), .o_ref_ts(a_ref), .o_orig_ts(a_orig),
    .o_recv_ts(a_recv), .o_xmit_ts(a_xmit), .o_dst_ts(a_dst));

  ntp_recv_parse #(.P_MIN_LEN(48), .P_CHECK_ORIGIN(1'b0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_valid(rx_valid), .i_rx_sof(rx_sof), .i_rx_eof(rx_eof),
    .i_rx_data(rx_data), .i_ntp_local(ntp_local), .i_ntp_client_send(CLIENT),
    .o_busy(b_busy), .o_ntp_valid(b_valid), .o_ntp_err(b_err), .o_err_code(b_code),
    .o_leap(b_leap), .o_version(b_version), .o_mode(b_mode), .o_stratum(b_stratum),
    .o_root_delay(b_delay), .o_root_disper(b_disper), .o_ref_ts(b_ref), .o_orig_ts(b_orig),
    .o_recv_ts(b_recv), .o_xmit_ts(b_xmit), .o_dst_ts(b_dst));

  typedef struct {
    logic [1:0]  leap;
    logic [2:0]  version;
    logic [2:0]  mode;
    logic [7:0]  stratum;
    logic [31:0] delay;
    logic [31:0] disper;
    logic [63:0] ref_ts;
    logic [63:0] orig;
    logic [63:0] recv;
    logic [63:0] xmit;
    logic [63:0] dst;
  } flds_t;

  typedef struct {
    int         cyc;
    bit         is_err;
    logic [2:0] code;
    flds_t      f;
  } ev_t;

  ev_t         evq_a[$];
  ev_t         evq_b[$];
  flds_t       mf[2];
  logic [2:0]  mc[2];
  logic [7:0]  pkt[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          busy_from = 0;
  int          busy_until = -1;
  bit          in_pkt = 1'b0;
  logic [63:0] last_t4 = 64'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  function automatic flds_t zero_f();
    flds_t z;
    z.leap = '0; z.version = '0; z.mode = '0; z.stratum = '0; z.delay = '0; z.disper = '0;
    z.ref_ts = '0; z.orig = '0; z.recv = '0; z.xmit = '0; z.dst = '0;
    return z;
  endfunction

  function automatic logic [63:0] be(input int ofs, input int nb);
    logic [63:0] v = 64'd0;
    for (int i = 0; i < nb; i++) v = {v[55:0], pkt[ofs+i]};
    return v;
  endfunction

  function automatic flds_t parse(input logic [63:0] t4);
    flds_t f;
    f.leap    = pkt[0][7:6];
    f.version = pkt[0][5:3];
    f.mode    = pkt[0][2:0];
    f.stratum = pkt[1];
    f.delay   = 32'(be(4, 4));
    f.disper  = 32'(be(8, 4));
    f.ref_ts  = be(16, 8);
    f.orig    = be(24, 8);
    f.recv    = be(32, 8);
    f.xmit    = be(40, 8);
    f.dst     = t4;
    return f;
  endfunction

  function automatic logic [2:0] model_code(input int n, input bit chk_orig);
    if (n < 48) return 3'd1;
    if (pkt[0][2:0] != 3'd4) return 3'd2;
    if (pkt[0][5:3] != 3'd3 && pkt[0][5:3] != 3'd4) return 3'd3;
    if (pkt[1] == 8'd0 || pkt[1] > 8'd15) return 3'd4;
    if (chk_orig && be(24, 8) != CLIENT) return 3'd5;
    return 3'd0;
  endfunction

  task automatic push_ev(input int w, input ev_t ev);
    if (w == 0) evq_a.push_back(ev);
    else        evq_b.push_back(ev);
  endtask

  task automatic make_pkt(input int n, input logic [7:0] b0, input logic [7:0] strat,
                          input logic [63:0] orig, input logic [63:0] xmit);
    pkt.delete();
    for (int i = 0; i < n; i++) pkt.push_back(8'((i * 37 + 11) & 255));
    pkt[0] = b0;
    if (n > 1) pkt[1] = strat;
    for (int i = 0; i < 8; i++) begin
      if (24 + i < n) pkt[24+i] = orig[63-8*i -: 8];
      if (40 + i < n) pkt[40+i] = xmit[63-8*i -: 8];
    end
  endtask

  // Sends pkt[0..n-1]; the model learns the outcome from the byte list at eof.
  task automatic send_pkt(input int n, input bit with_eof, input int gap_mod);
    ev_t ev;
    for (int i = 0; i < n; i++) begin
      rx_valid = 1'b1;
      rx_sof   = (i == 0);
      rx_eof   = with_eof && (i == n - 1);
      rx_data  = pkt[i];
      if (i == 0) last_t4 = ntp_local;
      @(posedge clk); #1;
      rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;
      if (i == 0) begin
        if (in_pkt) begin
          ev.cyc = cyc; ev.is_err = 1'b1; ev.code = 3'd6; ev.f = zero_f();
          push_ev(0, ev);
          push_ev(1, ev);
        end
        in_pkt     = 1'b1;
        busy_from  = cyc;
        busy_until = 32'h7FFF_FFFF;
      end
      if (with_eof && i == n - 1) begin
        in_pkt     = 1'b0;
        busy_until = cyc + 2;
        ev.cyc     = cyc + 2;
        ev.f       = (n >= 48) ? parse(last_t4) : zero_f();
        for (int w = 0; w < 2; w++) begin
          ev.code   = model_code(n, w == 0);
          ev.is_err = (ev.code != 3'd0);
          push_ev(w, ev);
        end
      end else if (gap_mod > 0 && (i % gap_mod) == gap_mod - 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    evq_a.delete();
    evq_b.delete();
    mf[0] = zero_f(); mf[1] = zero_f();
    mc[0] = 3'd0;     mc[1] = 3'd0;
    in_pkt = 1'b0;
    busy_until = -1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic check_dut(input string tag, input int w, input logic v, input logic e,
                           input logic bsy, input logic [2:0] code, input flds_t a);
    ev_t  ev;
    bit   hit = 1'b0;
    logic xv = 1'b0, xe = 1'b0, xb;
    if (w == 0 && evq_a.size() > 0 && evq_a[0].cyc == cyc) begin ev = evq_a.pop_front(); hit = 1'b1; end
    if (w == 1 && evq_b.size() > 0 && evq_b[0].cyc == cyc) begin ev = evq_b.pop_front(); hit = 1'b1; end
    if (hit) begin
      if (ev.is_err) begin xe = 1'b1; mc[w] = ev.code; end
      else begin xv = 1'b1; mf[w] = ev.f; end
    end
    xb = (cyc >= busy_from) && (cyc <= busy_until);
    chk({tag, ".ntp_valid"}, 64'(v), 64'(xv));
    chk({tag, ".ntp_err"}, 64'(e), 64'(xe));
    chk({tag, ".busy"}, 64'(bsy), 64'(xb));
    chk({tag, ".err_code"}, 64'(code), 64'(mc[w]));
    chk({tag, ".leap"}, 64'(a.leap), 64'(mf[w].leap));
    chk({tag, ".version"}, 64'(a.version), 64'(mf[w].version));
    chk({tag, ".mode"}, 64'(a.mode), 64'(mf[w].mode));
    chk({tag, ".stratum"}, 64'(a.stratum), 64'(mf[w].stratum));
    chk({tag, ".root_delay"}, 64'(a.delay), 64'(mf[w].delay));
    chk({tag, ".root_disper"}, 64'(a.disper), 64'(mf[w].disper));
    chk({tag, ".ref_ts"}, a.ref_ts, mf[w].ref_ts);
    chk({tag, ".orig_ts"}, a.orig, mf[w].orig);
    chk({tag, ".recv_ts"}, a.recv, mf[w].recv);
    chk({tag, ".xmit_ts"}, a.xmit, mf[w].xmit);
    chk({tag, ".dst_ts"}, a.dst, mf[w].dst);
  endtask

  flds_t fa, fb;
  always @(negedge clk) begin
    fa.leap = a_leap; fa.version = a_version; fa.mode = a_mode; fa.stratum = a_stratum;
    fa.delay = a_delay; fa.disper = a_disper; fa.ref_ts = a_ref; fa.orig = a_orig;
    fa.recv = a_recv; fa.xmit = a_xmit; fa.dst = a_dst;
    fb.leap = b_leap; fb.version = b_version; fb.mode = b_mode; fb.stratum = b_stratum;
    fb.delay = b_delay; fb.disper = b_disper; fb.ref_ts = b_ref; fb.orig = b_orig;
    fb.recv = b_recv; fb.xmit = b_xmit; fb.dst = b_dst;
    check_dut("a", 0, a_valid, a_err, a_busy, a_code, fa);
    check_dut("b", 1, b_valid, b_err, b_busy, b_code, fb);
  end

  // Literal latency pins on dut_a: nothing at eof+1, strobe at eof+2, quiet at eof+3.
  task automatic lit_after_eof(input string tag, input bit exp_valid, input logic [2:0] exp_code);
    @(posedge clk); #1;
    chk({tag, ".lit_early"}, {62'd0, a_valid, a_err}, 64'd0);
    chk({tag, ".lit_busy1"}, 64'(a_busy), 64'd1);
    @(posedge clk); #1;
    chk({tag, ".lit_valid"}, 64'(a_valid), 64'(exp_valid));
    chk({tag, ".lit_err"}, 64'(a_err), 64'(!exp_valid));
    if (!exp_valid) chk({tag, ".lit_code"}, 64'(a_code), 64'(exp_code));
    @(posedge clk); #1;
    chk({tag, ".lit_late"}, {62'd0, a_valid, a_err}, 64'd0);
    chk({tag, ".lit_busy0"}, 64'(a_busy), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog cycle=%0d got=timeout want=finish", cyc);
    $fatal(1);
  end

  initial begin
    mf[0] = zero_f(); mf[1] = zero_f();
    mc[0] = 3'd0;     mc[1] = 3'd0;
    do_reset();
    chk("rst.busy", 64'(a_busy), 64'd0);
    chk("rst.err_code", 64'(a_code), 64'd0);
    chk("rst.xmit", a_xmit, 64'd0);

    rx_valid = 1'b1; rx_data = 8'h55;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(posedge clk); #1;

    make_pkt(48, 8'h24, 8'd2, CLIENT, XMIT1);
    send_pkt(48, 1'b1, 5);
    lit_after_eof("good", 1'b1, 3'd0);
    chk("good.xmit", a_xmit, XMIT1);
    chk("good.orig", a_orig, CLIENT);
    chk("good.stratum", 64'(a_stratum), 64'd2);
    chk("good.version", 64'(a_version), 64'd4);
    chk("good.mode", 64'(a_mode), 64'd4);
    chk("good.delay", 64'(a_delay), 64'h9FC4_E90E);
    chk("good.dst", a_dst, last_t4);

    make_pkt(48, 8'h24, 8'd2, CLIENT ^ 64'd1, 64'hAAAA_BBBB_CCCC_DDDD);
    send_pkt(48, 1'b1, 0);
    lit_after_eof("orig", 1'b0, 3'd5);
    chk("orig.xmit_held", a_xmit, XMIT1);
    chk("orig.b_xmit", b_xmit, 64'hAAAA_BBBB_CCCC_DDDD);

    make_pkt(40, 8'h24, 8'd2, CLIENT, XMIT1);
    send_pkt(40, 1'b1, 7);
    lit_after_eof("len40", 1'b0, 3'd1);

    make_pkt(68, 8'h64, 8'd15, CLIENT, 64'h1122_3344_5566_7788);
    send_pkt(68, 1'b1, 0);
    lit_after_eof("len68", 1'b1, 3'd0);
    chk("len68.leap", 64'(a_leap), 64'd1);
    chk("len68.stratum", 64'(a_stratum), 64'd15);

    make_pkt(48, 8'h24, 8'd0, CLIENT, XMIT1);
    send_pkt(48, 1'b1, 0);
    lit_after_eof("strat0", 1'b0, 3'd4);
    make_pkt(48, 8'h24, 8'd16, CLIENT, XMIT1);
    send_pkt(48, 1'b1, 0);
    lit_after_eof("strat16", 1'b0, 3'd4);
    make_pkt(48, 8'h23, 8'd0, CLIENT, XMIT1);
    send_pkt(48, 1'b1, 0);
    lit_after_eof("mode3", 1'b0, 3'd2);
    make_pkt(48, 8'h2C, 8'd3, CLIENT, XMIT1);
    send_pkt(48, 1'b1, 0);
    lit_after_eof("vn5", 1'b0, 3'd3);
    make_pkt(48, 8'h1C, 8'd3, CLIENT, 64'h0000_0000_FFFF_FFFF);
    send_pkt(48, 1'b1, 3);
    lit_after_eof("vn3", 1'b1, 3'd0);
    chk("vn3.version", 64'(a_version), 64'd3);

    make_pkt(1, 8'h24, 8'd0, CLIENT, XMIT1);
    send_pkt(1, 1'b1, 0);
    lit_after_eof("len1", 1'b0, 3'd1);

    make_pkt(48, 8'h24, 8'd3, CLIENT, 64'h5555_5555_5555_5555);
    send_pkt(20, 1'b0, 0);
    make_pkt(48, 8'h24, 8'd4, CLIENT, 64'h6666_0000_7777_0000);
    send_pkt(48, 1'b1, 4);
    lit_after_eof("resync", 1'b1, 3'd0);
    chk("resync.code", 64'(a_code), 64'd6);
    chk("resync.stratum", 64'(a_stratum), 64'd4);
    chk("resync.xmit", a_xmit, 64'h6666_0000_7777_0000);
    chk("resync.dst", a_dst, last_t4);

    make_pkt(48, 8'h24, 8'd2, CLIENT, XMIT1);
    send_pkt(30, 1'b0, 0);
    do_reset();
    chk("rst2.xmit", a_xmit, 64'd0);
    chk("rst2.stratum", 64'(a_stratum), 64'd0);
    chk("rst2.code", 64'(a_code), 64'd0);
    make_pkt(48, 8'h24, 8'd2, CLIENT, XMIT1);
    send_pkt(48, 1'b1, 0);
    lit_after_eof("after_rst", 1'b1, 3'd0);
    chk("after_rst.xmit", a_xmit, XMIT1);

    repeat (4) @(posedge clk);
    #1 chk("events_drained", 64'(evq_a.size() + evq_b.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
